egress_port_queue: RTL and testbench
====================================

// Module: egress_port_queue
// PURPOSE
//  Output-side consumer of the scheduler's per-port write stream (out_ram_wrN / outputN).
//  - Buffers each scheduled 32-bit word in a circular RAM.
//  - Drains the RAM to the egress link over a valid/ready handshake.
//  - One instance per switch output port (3 in the current switch).
// PARAMETERS
//  DATA_W  32  word width; bits [1:0] carry the destination-port tag
//  ADDR_W  12  RAM address width; DEPTH = 2**ADDR_W = 4096 words
// PORTS
//  clk          in   1           single clock, all logic on posedge
//  reset        in   1           synchronous, active-high
//  sched_wr     in   1           write strobe from scheduler (out_ram_wrN)
//  sched_data   in   DATA_W      word from scheduler (outputN)
//  tx_data      out  DATA_W      egress word
//  tx_valid     out  1           tx_data valid
//  tx_ready     in   1           link accepts tx_data
//  wr_add       out  ADDR_W      current write address (wr_ptr low bits)
//  rd_add       out  ADDR_W      current read address (rd_ptr low bits)
//  occupancy    out  ADDR_W+1    words stored, 0..DEPTH
//  full         out  1           occupancy == DEPTH
//  empty        out  1           occupancy == 0
//  drop_count   out  16          words dropped on full, saturating
// BEHAVIOUR
//  Reset:
//  - wr_ptr, rd_ptr, drop_count, tx_data, tx_valid are all 0.
//  - FSM in IDLE; full=0, empty=1.
//  - Asserting reset mid-operation discards the held word and all queued data on that edge.
//  Pointers:
//  - wr_ptr and rd_ptr are ADDR_W+1 bits; occupancy = wr_ptr - rd_ptr (modulo).
//  - Address wraps 4095->0; the extra MSB distinguishes full from empty.
//  Write:
//  - sched_wr && !full: RAM[wr_ptr] <= sched_data, wr_ptr++.
//  - sched_wr && full: word dropped; drop_count++ (saturates at 16'hFFFF); pointers unchanged.
//  FSM (RAM read latency = 1 cycle):
//  - IDLE:  if !empty, issue read at rd_ptr -> FETCH.
//  - FETCH: capture RAM data into tx_data, tx_valid<=1 -> HOLD.
//  - HOLD:  tx_data and tx_valid hold until tx_valid&&tx_ready; then rd_ptr++ and:
//           - if occupancy after pop > 0, read rd_ptr+1 -> FETCH
//           - else tx_valid<=0 -> IDLE.
//  Latency and throughput:
//  - sched_wr at edge E0 into an empty queue -> tx_valid=1 after edge E2.
//  - Throughput is 1 word per 2 cycles, matching the scheduler's alternating write cycle.
//  Occupancy accounting:
//  - The word in HOLD stays counted in occupancy until its handshake.
//  - Simultaneous write and pop on one edge: occupancy unchanged; both pointers advance.
//  - A write into a full queue on the same edge as a pop is still dropped (full is sampled pre-edge).
//  - tx_ready is ignored when tx_valid=0.
// CONFIGURATION
//  EGRESS_TAG_STRIP_EN
//  - Defined: tx_data[1:0] forced to 2'b00 (destination tag removed before the link).
//  - Undefined: tx_data equals the stored word bit-for-bit.
//  - Buffering, pointer and drop behaviour are identical in both builds.
// STRUCTURE
//  Package switch_pkg:
//  - DATA_W, ADDR_W, DEPTH constants
//  - typedef logic [DATA_W-1:0] word_t
//  - typedef logic [1:0] port_tag_t
//  - typedef enum {IDLE, FETCH, HOLD} egress_state_e
//  Sub-module egress_ram:
//  - simple dual-port RAM: 1 write port, 1 registered read port, no reset on contents.
// TESTING
//  1. Reset, no stimulus, 20 cycles -> tx_valid=0, empty=1, occupancy=0, drop_count=0.
//  2. Single write 32'hDEAD_BEE1 at E0, tx_ready=1 -> tx_valid high after E2 with that data;
//     one cycle later empty=1, rd_add=1.
//  3. Write 5 words on alternate cycles with tx_ready=0 -> occupancy=5 and first word held stable;
//     raise tx_ready -> 5 words out in order, one per 2 cycles.
//  4. Fill 4096 words, then write 3 more -> full=1, drop_count=3; drain all -> data in order,
//     wr_add/rd_add wrap to 0.
//  5. Occupancy=2 in HOLD, assert reset for 1 cycle -> next cycle tx_valid=0, occupancy=0,
//     previously held word never appears.
//  6. Build with EGRESS_TAG_STRIP_EN, write 32'h1234_5677 -> tx_data=32'h1234_5674;
//     without the macro -> 32'h1234_5677.

Source files
------------

// File: rtl/switch_pkg.sv
// -----------------------------------------------------------------------------
// switch_pkg
// Shared constants and types for the switch egress path.
//   DATA_W          word width; bits [1:0] carry the destination-port tag
//   ADDR_W          egress RAM address width
//   DEPTH           egress RAM depth in words (2**ADDR_W)
//   word_t          one scheduled word
//   port_tag_t      destination-port tag carried in word_t[1:0]
//   egress_state_e  drain FSM states
// -----------------------------------------------------------------------------
package switch_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [1:0]        port_tag_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } egress_state_e;

endpackage

// File: rtl/egress_ram.sv
// -----------------------------------------------------------------------------
// egress_ram
// Simple dual-port RAM: one write port, one registered read port (1-cycle
// latency). Contents are not reset.
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write word
//   rd_en    in   read strobe; rd_data updates on the following edge
//   rd_addr  in   read address
//   rd_data  out  registered read word
// -----------------------------------------------------------------------------
module egress_ram
  import switch_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  word_t             wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output word_t             rd_data
);

  word_t mem_r [0:DEPTH-1];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/egress_port_queue.sv
// -----------------------------------------------------------------------------
// egress_port_queue
// Buffers the scheduler's per-port word stream in a circular RAM and drains it
// to the egress link over a valid/ready handshake (one word per two cycles).
// Build option: define EGRESS_TAG_STRIP_EN to clear tx_data[1:0] (destination
// tag) before the link; otherwise tx_data is the stored word unchanged.
// Ports:
//   clk         in   clock, all logic on posedge
//   reset       in   synchronous active-high reset
//   sched_wr    in   write strobe from scheduler
//   sched_data  in   word from scheduler
//   tx_data     out  egress word (registered)
//   tx_valid    out  tx_data valid (registered)
//   tx_ready    in   link accepts tx_data
//   wr_add      out  current write address
//   rd_add      out  current read address
//   occupancy   out  words stored, 0..DEPTH (held word included)
//   full        out  occupancy == DEPTH
//   empty       out  occupancy == 0
//   drop_count  out  words dropped on full, saturating
// -----------------------------------------------------------------------------
module egress_port_queue
  import switch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              sched_wr,
  input  logic [DATA_W-1:0] sched_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] wr_add,
  output logic [ADDR_W-1:0] rd_add,
  output logic [ADDR_W:0]   occupancy,
  output logic              full,
  output logic              empty,
  output logic [15:0]       drop_count
);

  localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   OCC_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1);

  // Word presented to the link, with the destination tag optionally removed.
  function automatic word_t egress_word(input word_t w);
    word_t o;
    o = w;
`ifdef EGRESS_TAG_STRIP_EN
    o[1:0] = port_tag_t'(2'b00);
`endif
    return o;
  endfunction

  logic [ADDR_W:0] wr_ptr_r;
  logic [ADDR_W:0] rd_ptr_r;
  logic [ADDR_W:0] occ_s;
  logic            full_s;
  logic            empty_s;
  logic            wr_en_s;
  logic            rd_en_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic            load_s;
  logic            pop_s;
  word_t           ram_q_s;
  word_t           tx_data_r;
  logic            tx_valid_r;
  logic [15:0]     drop_count_r;
  egress_state_e   state_r;
  egress_state_e   state_nxt_s;

  // The extra pointer MSB makes the modulo difference span 0..DEPTH.
  assign occ_s   = wr_ptr_r - rd_ptr_r;
  assign full_s  = (occ_s == DEPTH_V);
  assign empty_s = (occ_s == '0);
  assign wr_en_s = sched_wr && !full_s;

  egress_ram u_ram (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_addr (wr_ptr_r[ADDR_W-1:0]),
    .wr_data (sched_data),
    .rd_en   (rd_en_s),
    .rd_addr (rd_addr_s),
    .rd_data (ram_q_s)
  );

  // Drain FSM next-state and RAM read control.
  always_comb begin
    state_nxt_s = state_r;
    rd_en_s     = 1'b0;
    rd_addr_s   = rd_ptr_r[ADDR_W-1:0];
    load_s      = 1'b0;
    pop_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          rd_en_s     = 1'b1;
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FETCH: begin
        load_s      = 1'b1;
        state_nxt_s = HOLD;
      end
      HOLD: begin
        if (tx_valid_r && tx_ready) begin
          pop_s = 1'b1;
          // Prefetch only words already stored before this edge, so the read
          // never targets the address being written on the same edge.
          if (occ_s > OCC_ONE) begin
            rd_en_s     = 1'b1;
            rd_addr_s   = rd_ptr_r[ADDR_W-1:0] + ADR_ONE;
            state_nxt_s = FETCH;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Write and read pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Egress output register; valid drops on every pop so a word is shown once.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data_r  <= '0;
      tx_valid_r <= 1'b0;
    end else if (load_s) begin
      tx_data_r  <= egress_word(ram_q_s);
      tx_valid_r <= 1'b1;
    end else if (pop_s) begin
      tx_valid_r <= 1'b0;
    end
  end

  // Saturating drop counter; full is the pre-edge value.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count_r <= 16'h0000;
    end else if (sched_wr && full_s && (drop_count_r != 16'hFFFF)) begin
      drop_count_r <= drop_count_r + 16'h0001;
    end
  end

  assign tx_data    = tx_data_r;
  assign tx_valid   = tx_valid_r;
  assign wr_add     = wr_ptr_r[ADDR_W-1:0];
  assign rd_add     = rd_ptr_r[ADDR_W-1:0];
  assign occupancy  = occ_s;
  assign full       = full_s;
  assign empty      = empty_s;
  assign drop_count = drop_count_r;

endmodule

// File: tb/tb_egress_port_queue.sv
// -----------------------------------------------------------------------------
// tb_egress_port_queue
// Self-checking bench: directed scenarios plus random traffic. A reference
// model (a queue of accepted words plus a drop counter) is updated on every
// clock; a monitor compares status outputs each cycle and pops/compares the
// expected word on each link handshake.
// -----------------------------------------------------------------------------
module tb_egress_port_queue;

  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int DEPTH = 4096;

  logic          clk = 1'b0;
  logic          reset;
  logic          sched_wr;
  logic [DW-1:0] sched_data;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [AW-1:0] wr_add;
  logic [AW-1:0] rd_add;
  logic [AW:0]   occupancy;
  logic          full;
  logic          empty;
  logic [15:0]   drop_count;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  logic [DW-1:0] sb[$];
  int            model_drops = 0;
  bit            hold_prev = 1'b0;
  logic [DW-1:0] held_data;

  egress_port_queue dut (
    .clk        (clk),
    .reset      (reset),
    .sched_wr   (sched_wr),
    .sched_data (sched_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .wr_add     (wr_add),
    .rd_add     (rd_add),
    .occupancy  (occupancy),
    .full       (full),
    .empty      (empty),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_word(input logic [DW-1:0] w);
    logic [DW-1:0] o;
    o = w;
`ifdef EGRESS_TAG_STRIP_EN
    o[1:0] = 2'b00;
`endif
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor + reference model: compare state after the last edge, then
  // account for what the coming edge does with the (stable) inputs.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    bit            was_full;
    if (mon_en) begin
      chk("occupancy", 32'(occupancy), 32'(sb.size()));
      chk("full", 32'(full), 32'(sb.size() == DEPTH));
      chk("empty", 32'(empty), 32'(sb.size() == 0));
      chk("drop_count", 32'(drop_count), 32'(model_drops));
      if (hold_prev && tx_valid) chk("held_stable", tx_data, held_data);
    end
    if (reset) begin
      sb.delete();
      model_drops = 0;
      hold_prev   = 1'b0;
    end else if (mon_en) begin
      was_full = (sb.size() == DEPTH);
      if (tx_valid && tx_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %h expected none", tx_data);
        end else begin
          e = sb.pop_front();
          chk("tx_data", tx_data, exp_word(e));
        end
      end
      if (sched_wr) begin
        if (was_full) begin
          if (model_drops != 65535) model_drops++;
        end else begin
          sb.push_back(sched_data);
        end
      end
      hold_prev = tx_valid && !tx_ready;
      held_data = tx_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    sched_wr = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Wait for the queue to empty and the link to go idle; timeout is a failure.
  task automatic drain(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(empty && !tx_valid) && n < budget);
    chk("drain_done", 32'(empty && !tx_valid), 32'd1);
  endtask

  initial begin
    int n;
    logic [DW-1:0] first;
    reset      = 1'b1;
    sched_wr   = 1'b0;
    sched_data = '0;
    tx_ready   = 1'b0;
    tick();
    mon_en = 1'b1;
    do_reset();

    // 1: idle after reset
    repeat (20) tick();
    chk("t1_tx_valid", 32'(tx_valid), 32'd0);
    chk("t1_empty", 32'(empty), 32'd1);
    chk("t1_occ", 32'(occupancy), 32'd0);
    chk("t1_drops", 32'(drop_count), 32'd0);

    // 2: single word latency
    tx_ready   = 1'b1;
    sched_wr   = 1'b1;
    sched_data = 32'hDEAD_BEE1;
    tick();
    sched_wr = 1'b0;
    chk("t2_valid_e0", 32'(tx_valid), 32'd0);
    tick();
    chk("t2_valid_e1", 32'(tx_valid), 32'd0);
    tick();
    chk("t2_valid_e2", 32'(tx_valid), 32'd1);
    chk("t2_data", tx_data, exp_word(32'hDEAD_BEE1));
    tick();
    chk("t2_empty", 32'(empty), 32'd1);
    chk("t2_rd_add", 32'(rd_add), 32'd1);
    chk("t2_valid_off", 32'(tx_valid), 32'd0);

    // 3: five words held back, then drained at one per two cycles
    tx_ready = 1'b0;
    first    = 32'hA5A5_0001;
    for (int i = 0; i < 5; i++) begin
      sched_wr   = 1'b1;
      sched_data = (i == 0) ? first : $urandom;
      tick();
      sched_wr = 1'b0;
      tick();
    end
    repeat (3) tick();
    chk("t3_occ", 32'(occupancy), 32'd5);
    chk("t3_held", tx_data, exp_word(first));
    tx_ready = 1'b1;
    drain(40, n);
    chk("t3_drain_cycles", 32'(n), 32'd9);

    // 4: fill, overflow, drain with address wrap
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      sched_wr   = 1'b1;
      sched_data = $urandom;
      tick();
    end
    sched_wr = 1'b0;
    tick();
    chk("t4_full", 32'(full), 32'd1);
    chk("t4_drops", 32'(drop_count), 32'd3);
    chk("t4_wr_add", 32'(wr_add), 32'd0);
    tx_ready = 1'b1;
    drain(9000, n);
    chk("t4_wr_wrap", 32'(wr_add), 32'd0);
    chk("t4_rd_wrap", 32'(rd_add), 32'd0);

    // 5: reset while holding a word discards everything
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sched_wr   = 1'b1;
      sched_data = $urandom;
      tick();
      sched_wr = 1'b0;
      tick();
    end
    n = 0;
    while (!tx_valid && n < 20) begin
      tick();
      n++;
    end
    chk("t5_holding", 32'(tx_valid), 32'd1);
    chk("t5_occ", 32'(occupancy), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_valid", 32'(tx_valid), 32'd0);
    chk("t5_occ_clr", 32'(occupancy), 32'd0);
    tx_ready = 1'b1;
    repeat (6) tick();
    chk("t5_no_ghost", 32'(tx_valid), 32'd0);

    // 6: tag handling
    tx_ready   = 1'b0;
    sched_wr   = 1'b1;
    sched_data = 32'h1234_5677;
    tick();
    sched_wr = 1'b0;
    n = 0;
    while (!tx_valid && n < 20) begin
      tick();
      n++;
    end
`ifdef EGRESS_TAG_STRIP_EN
    chk("t6_tag", tx_data, 32'h1234_5674);
`else
    chk("t6_tag", tx_data, 32'h1234_5677);
`endif
    tx_ready = 1'b1;
    drain(20, n);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      sched_wr   = ($urandom_range(0, 2) != 0);
      sched_data = $urandom;
      tx_ready   = ($urandom_range(0, 3) != 0);
      tick();
    end
    sched_wr = 1'b0;
    tx_ready = 1'b1;
    drain(9000, n);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
